// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: opcodes, ALU codes,
// instruction field positions and the decoded control bundle.
package mips16_pkg;

    typedef logic [3:0] opcode_t;
    typedef logic [2:0] alu_t;

    localparam opcode_t OP_RTYPE = 4'd0;
    localparam opcode_t OP_ADDI  = 4'd1;
    localparam opcode_t OP_LW    = 4'd2;
    localparam opcode_t OP_SW    = 4'd3;
    localparam opcode_t OP_BEQ   = 4'd4;
    localparam opcode_t OP_JMP   = 4'd5;

    localparam alu_t ALU_ADD = 3'd0;
    localparam alu_t ALU_SUB = 3'd1;
    localparam alu_t ALU_AND = 3'd2;
    localparam alu_t ALU_OR  = 3'd3;
    localparam alu_t ALU_SLT = 3'd4;

    localparam int unsigned OP_MSB    = 15;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RS_MSB    = 11;
    localparam int unsigned RS_LSB    = 9;
    localparam int unsigned RT_MSB    = 8;
    localparam int unsigned RT_LSB    = 6;
    localparam int unsigned RD_MSB    = 5;
    localparam int unsigned RD_LSB    = 3;
    localparam int unsigned FUNCT_MSB = 2;
    localparam int unsigned IMM6_MSB  = 5;
    localparam int unsigned IMM12_MSB = 11;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
        alu_t alu_ctrl;
    } ctrl_t;

    typedef enum logic [1:0] {DestNone, DestRd, DestRt} dest_sel_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode/funct decoder: control bundle, destination select and
// which source registers the instruction actually reads.
module decode_ctrl
    import mips16_pkg::*;
(
    input  opcode_t    op_i,
    input  alu_t       funct_i,
    output ctrl_t      ctrl_o,
    output dest_sel_t  dest_sel_o,
    output logic       uses_rs_o,
    output logic       uses_rt_o
);

    always_comb begin
        ctrl_o     = '0;
        dest_sel_o = DestNone;
        uses_rs_o  = 1'b0;
        uses_rt_o  = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_ctrl  = funct_i;
                dest_sel_o       = DestRd;
                uses_rs_o        = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_ctrl  = ALU_ADD;
                dest_sel_o       = DestRt;
                uses_rs_o        = 1'b1;
            end
            OP_LW: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                dest_sel_o       = DestRt;
                uses_rs_o        = 1'b1;
            end
            OP_SW: begin
                ctrl_o.mem_write = 1'b1;
                uses_rs_o        = 1'b1;
                uses_rt_o        = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.branch   = 1'b1;
                ctrl_o.alu_ctrl = ALU_SUB;
                uses_rs_o       = 1'b1;
                uses_rt_o       = 1'b1;
            end
            OP_JMP: begin
                ctrl_o.jump = 1'b1;
            end
            default: begin
                ctrl_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file addressing, write-back bypass,
// load-use stall, branch flush and the ID/EX pipeline register.
module decode_stage
    import mips16_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    output logic              id_ready,
    output logic [ADDR_W-1:0] rf_rd_addr_1,
    output logic [ADDR_W-1:0] rf_rd_addr_2,
    input  logic [DATA_W-1:0] rf_rd_data_1,
    input  logic [DATA_W-1:0] rf_rd_data_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [PC_W-1:0]   ex_pc,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_wr_dest,
    output logic [2:0]        ex_alu_ctrl,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic              ex_jump,
    output logic              ex_illegal
);

    logic [ADDR_W-1:0] rs, rt, rd, dest;
    logic [DATA_W-1:0] op_a, op_b, imm;
    ctrl_t             ctrl;
    dest_sel_t         dest_sel;
    logic              uses_rs, uses_rt, hazard, load_en, transfer;

    logic              ex_valid_q, ex_valid_d;
    logic [PC_W-1:0]   ex_pc_q, ex_pc_d;
    logic [DATA_W-1:0] ex_op_a_q, ex_op_a_d, ex_op_b_q, ex_op_b_d, ex_imm_q, ex_imm_d;
    logic [ADDR_W-1:0] ex_wr_dest_q, ex_wr_dest_d;
    ctrl_t             ex_ctrl_q, ex_ctrl_d;

    assign rs = if_instr[RS_MSB:RS_LSB];
    assign rt = if_instr[RT_MSB:RT_LSB];
    assign rd = if_instr[RD_MSB:RD_LSB];

    assign rf_rd_addr_1 = rs;
    assign rf_rd_addr_2 = rt;

    decode_ctrl u_decode_ctrl (
        .op_i       (if_instr[OP_MSB:OP_LSB]),
        .funct_i    (if_instr[FUNCT_MSB:0]),
        .ctrl_o     (ctrl),
        .dest_sel_o (dest_sel),
        .uses_rs_o  (uses_rs),
        .uses_rt_o  (uses_rt)
    );

    always_comb begin
        case (dest_sel)
            DestRd:  dest = rd;
            DestRt:  dest = rt;
            default: dest = '0;
        endcase
    end

    assign imm = ctrl.jump ? {{(DATA_W-12){1'b0}}, if_instr[IMM12_MSB:0]}
                           : {{(DATA_W-6){if_instr[IMM6_MSB]}}, if_instr[IMM6_MSB:0]};

    // r0 is hard-wired to zero, so it is never bypassed from write-back either.
    always_comb begin
        if (rs == '0)                       op_a = '0;
        else if (wb_en && (wb_dest == rs))  op_a = wb_data;
        else                                op_a = rf_rd_data_1;
        if (rt == '0)                       op_b = '0;
        else if (wb_en && (wb_dest == rt))  op_b = wb_data;
        else                                op_b = rf_rd_data_2;
    end

    assign hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_wr_dest_q != '0) &&
                    ((uses_rs && (ex_wr_dest_q == rs)) || (uses_rt && (ex_wr_dest_q == rt)));

    assign load_en  = ex_ready || !ex_valid_q;
    assign id_ready = !rst && load_en && !hazard && !flush;
    assign transfer = if_valid && id_ready;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_pc_d      = ex_pc_q;
        ex_op_a_d    = ex_op_a_q;
        ex_op_b_d    = ex_op_b_q;
        ex_imm_d     = ex_imm_q;
        ex_wr_dest_d = ex_wr_dest_q;
        ex_ctrl_d    = ex_ctrl_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (load_en) begin
            ex_valid_d = transfer;
            if (transfer) begin
                ex_pc_d      = if_pc;
                ex_op_a_d    = op_a;
                ex_op_b_d    = op_b;
                ex_imm_d     = imm;
                ex_wr_dest_d = dest;
                ex_ctrl_d    = ctrl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_op_a_q    <= '0;
            ex_op_b_q    <= '0;
            ex_imm_q     <= '0;
            ex_wr_dest_q <= '0;
            ex_ctrl_q    <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_pc_q      <= ex_pc_d;
            ex_op_a_q    <= ex_op_a_d;
            ex_op_b_q    <= ex_op_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_wr_dest_q <= ex_wr_dest_d;
            ex_ctrl_q    <= ex_ctrl_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_pc        = ex_pc_q;
    assign ex_op_a      = ex_op_a_q;
    assign ex_op_b      = ex_op_b_q;
    assign ex_imm       = ex_imm_q;
    assign ex_wr_dest   = ex_wr_dest_q;
    assign ex_alu_ctrl  = ex_ctrl_q.alu_ctrl;
    assign ex_reg_write = ex_ctrl_q.reg_write;
    assign ex_mem_read  = ex_ctrl_q.mem_read;
    assign ex_mem_write = ex_ctrl_q.mem_write;
    assign ex_branch    = ex_ctrl_q.branch;
    assign ex_jump      = ex_ctrl_q.jump;
    assign ex_illegal   = ex_ctrl_q.illegal;

endmodule
